pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk_i  in  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 pause_i  in  1  downstream stall; the IF register is holding this cycle.
REQ-005 redirect_i  in  1  taken branch/jump; the next fetch comes from redirect_pc_i.
REQ-006 redirect_pc_i  in  32  redirect target; bits [1:0] SHALL be treated as 0.
REQ-007 imem_req_o  out  1  instruction-memory request.
REQ-008 imem_addr_o  out  32  request address, driven from internal addr_r.
REQ-009 imem_ack_i  in  1  memory has accepted the request and imem_data_i is valid; may assert in the same cycle as the request.
REQ-010 imem_data_i  in  32  instruction word, valid only with imem_ack_i.
REQ-011 inst_o  out  32  instruction to the IF register inst_i input.
REQ-012 pc_o  out  32  PC of inst_o, to the IF register pc_i input.
REQ-013 valid_o  out  1  inst_o and pc_o carry a real instruction this cycle.
REQ-014 flush_o  out  1  drives the IF register flush input; flush_o = redirect_i | ~valid_o.

Function
REQ-015 The FSM SHALL have four states: BOOT, WAIT, DROP and HOLD. Registers: addr_r, tgt_r, buf_inst, buf_pc.
REQ-016 BOOT: imem_req_o=0, valid_o=0, and the FSM SHALL move to WAIT after one cycle.
REQ-017 WAIT: imem_req_o=1 and imem_addr_o=addr_r; addr_r SHALL stay stable until imem_ack_i.
REQ-018 WAIT, ack=1, redirect_i=0, pause_i=0: valid_o=1, inst_o=imem_data_i and pc_o=addr_r in the same cycle; then addr_r<=addr_r+4 and the FSM stays in WAIT. This gives 1 instr/cycle with a same-cycle ack.
REQ-019 WAIT, ack=1, pause_i=1, redirect_i=0: valid_o=0; buf_inst<=imem_data_i, buf_pc<=addr_r, addr_r<=addr_r+4; the FSM moves to HOLD.
REQ-020 WAIT, ack=1, redirect_i=1: the fetched data SHALL be discarded with valid_o=0; addr_r<=redirect_pc_i and the FSM stays in WAIT.
REQ-021 WAIT, ack=0, redirect_i=1: tgt_r<=redirect_pc_i and the FSM moves to DROP; addr_r is unchanged.
REQ-022 WAIT, ack=0, redirect_i=0: valid_o=0 and the FSM holds.
REQ-023 DROP: imem_req_o=1, imem_addr_o=addr_r (the stale request), valid_o=0.
  - A new redirect_i SHALL overwrite tgt_r (latest redirect wins).
  - On ack: addr_r<=(redirect_i ? redirect_pc_i : tgt_r) and the FSM moves to WAIT.
REQ-024 HOLD: imem_req_o=0, inst_o=buf_inst, pc_o=buf_pc, valid_o=~pause_i & ~redirect_i.
  - When pause_i=0 and redirect_i=0, the FSM SHALL move to WAIT.
  - When redirect_i=1, buf_inst is discarded, addr_r<=redirect_pc_i and the FSM moves to WAIT.
REQ-025 redirect_i SHALL take priority over pause_i and over imem_ack_i in every state.
REQ-026 When valid_o=0, inst_o SHALL be 32'h0 and pc_o SHALL be 32'h0.
REQ-027 addr_r increment SHALL wrap modulo 2^32: 32'hFFFF_FFFC+4 gives 32'h0000_0000.
REQ-028 imem_ack_i in BOOT or HOLD, where no request is outstanding, SHALL be ignored.
REQ-029 At most one memory request SHALL be outstanding at any time; pc_fetch issues no speculative second request.

Reset
REQ-030 On rst_i=1, without waiting for a clock edge:
  - state=BOOT, addr_r=RESET_PC, tgt_r=0, buf_inst=0, buf_pc=0.
  - imem_req_o=0, valid_o=0, inst_o=0, pc_o=0, flush_o=1.
REQ-031 Reset asserted mid-request (WAIT or DROP) SHALL abandon the request; a late ack arriving after reset, while the FSM is in BOOT, SHALL be ignored.
REQ-032 After rst_i falls, the first request SHALL issue 1 cycle later with imem_addr_o=RESET_PC.

Verification
REQ-033 Reset release, memory acks every cycle -> pc_o = 0,4,8,C on consecutive cycles with valid_o=1; first imem_req_o one cycle after release.
REQ-034 Ack with pause_i=1 held 3 cycles at addr 0x10 -> HOLD entered; imem_req_o=0 for those cycles; buffered word presented with pc_o=0x10 the cycle pause_i drops; next request addr=0x14.
REQ-035 redirect_i=1 to 0x200 while a request at 0x8 is unacked, ack arrives 2 cycles later -> valid_o=0 throughout; data for 0x8 never appears; next imem_addr_o=0x200.
REQ-036 redirect_i=1 with redirect_pc_i=0x103 in the same cycle as ack -> valid_o=0, flush_o=1; next imem_addr_o=0x100.
REQ-037 addr_r=0xFFFF_FFFC fetched -> next imem_addr_o=0x0000_0000.
REQ-038 rst_i pulsed while in DROP -> imem_req_o=0 immediately; restart at RESET_PC; the late ack is ignored.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch stage with one outstanding request, pause buffering and redirect handling.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pause_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        flush_o
);
  typedef enum logic [1:0] {BOOT, WAIT, DROP, HOLD} state_t;
  state_t      state;
  logic [31:0] addr_r, tgt_r, buf_inst, buf_pc, rpc;
  logic        live, held;
  assign rpc = redirect_pc_i & ~32'h3;
  assign live = state == WAIT && imem_ack_i && !redirect_i && !pause_i;
  assign held = state == HOLD && !pause_i && !redirect_i;
  assign valid_o = live | held;
  assign inst_o = held ? buf_inst : live ? imem_data_i : '0;
  assign pc_o = held ? buf_pc : live ? addr_r : '0;
  assign imem_req_o = state == WAIT || state == DROP;
  assign imem_addr_o = addr_r;
  assign flush_o = redirect_i | ~valid_o;
  // A redirect while the request is unacked must still wait out that stale ack (DROP).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= BOOT;
      addr_r <= RESET_PC;
      tgt_r <= '0;
      buf_inst <= '0;
      buf_pc <= '0;
    end else begin
      case (state)
        BOOT: state <= WAIT;
        WAIT: begin
          if (imem_ack_i) begin
            if (redirect_i) addr_r <= rpc;
            else begin
              addr_r <= addr_r + 32'd4;
              if (pause_i) begin
                buf_inst <= imem_data_i;
                buf_pc <= addr_r;
                state <= HOLD;
              end
            end
          end else if (redirect_i) begin
            tgt_r <= rpc;
            state <= DROP;
          end
        end
        DROP: begin
          if (redirect_i) tgt_r <= rpc;
          if (imem_ack_i) begin
            addr_r <= redirect_i ? rpc : tgt_r;
            state <= WAIT;
          end
        end
        default: begin
          if (redirect_i) addr_r <= rpc;
          if (redirect_i || !pause_i) state <= WAIT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: vector table, directed corner sequences and randomized run against a flag-based fetch model.
module tb_pc_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam bit O = 1'b0, I = 1'b1;
  logic        clk = 1'b0, rst = 1'b0, pause = 1'b0, redir = 1'b0, ack = 1'b0;
  logic [31:0] rpc = '0, data = '0;
  logic        req, valid, flush;
  logic [31:0] addr, inst, pc;
  int          n_chk = 0, n_pass = 0;
  bit          m_boot, m_held, m_stale;
  logic [31:0] m_addr, m_tgt, m_bi, m_bp;
  typedef struct {
    bit p, r;
    logic [31:0] rpc;
    bit a, ev, ereq, efl;
    logic [31:0] epc, eaddr;
  } vec_t;
  vec_t tbl[13];

  pc_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_i(rst), .pause_i(pause), .redirect_i(redir), .redirect_pc_i(rpc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .inst_o(inst), .pc_o(pc), .valid_o(valid), .flush_o(flush)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit p, bit r, logic [31:0] rp, bit a, bit ev, bit ereq, bit efl,
                              logic [31:0] epc, logic [31:0] eaddr);
    vec_t v;
    v.p = p; v.r = r; v.rpc = rp; v.a = a; v.ev = ev; v.ereq = ereq; v.efl = efl;
    v.epc = epc; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endtask

  task automatic model_reset();
    m_boot = 1; m_held = 0; m_stale = 0;
    m_addr = RESET_PC; m_tgt = '0; m_bi = '0; m_bp = '0;
  endtask

  // Called just after a rising edge: async reset mid-cycle, checked before the next edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_flush", {31'b0, flush}, 1);
    chk("rst_inst", inst, 0);
    chk("rst_pc", pc, 0);
    chk("rst_addr", addr, RESET_PC);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    pause = 0; redir = 0; ack = 0;
  endtask

  task automatic cyc(input bit p, input bit r, input logic [31:0] rp, input bit a, input logic [31:0] d,
                     output logic ov, output logic [31:0] opc, output logic oreq,
                     output logic [31:0] oaddr, output logic ofl);
    bit ev, live;
    logic [31:0] ei, ep, rm;
    @(negedge clk);
    pause = p; redir = r; rpc = rp; ack = a; data = d;
    #1;
    live = !m_boot && !m_held && !m_stale;
    ev = m_held ? (!p && !r) : (live && a && !r && !p);
    ei = !ev ? 32'h0 : m_held ? m_bi : d;
    ep = !ev ? 32'h0 : m_held ? m_bp : m_addr;
    chk("req", {31'b0, req}, {31'b0, !m_boot && !m_held});
    chk("addr", addr, m_addr);
    chk("valid", {31'b0, valid}, {31'b0, ev});
    chk("inst", inst, ei);
    chk("pc", pc, ep);
    chk("flush", {31'b0, flush}, {31'b0, r || !ev});
    ov = valid; opc = pc; oreq = req; oaddr = addr; ofl = flush;
    @(posedge clk);
    rm = rp & ~32'h3;
    if (m_boot) m_boot = 0;
    else if (m_held) begin
      if (r) m_addr = rm;
      if (r || !p) m_held = 0;
    end else if (m_stale) begin
      if (r) m_tgt = rm;
      if (a) begin m_addr = m_tgt; m_stale = 0; end
    end else if (a) begin
      if (r) m_addr = rm;
      else begin
        if (p) begin m_held = 1; m_bi = d; m_bp = m_addr; end
        m_addr = m_addr + 4;
      end
    end else if (r) begin
      m_stale = 1; m_tgt = rm;
    end
  endtask

  initial begin
    logic v, rq, fl;
    logic [31:0] p_, a_;
    tbl[0]  = mk(O, O, 0,      I, O, O, I, 0,      0);
    tbl[1]  = mk(O, O, 0,      I, I, I, O, 0,      0);
    tbl[2]  = mk(O, O, 0,      I, I, I, O, 4,      4);
    tbl[3]  = mk(O, O, 0,      I, I, I, O, 8,      8);
    tbl[4]  = mk(O, O, 0,      I, I, I, O, 'hC,    'hC);
    tbl[5]  = mk(I, O, 0,      I, O, I, I, 0,      'h10);
    tbl[6]  = mk(I, O, 0,      O, O, O, I, 0,      'h14);
    tbl[7]  = mk(I, O, 0,      I, O, O, I, 0,      'h14);
    tbl[8]  = mk(O, O, 0,      I, I, O, O, 'h10,   'h14);
    tbl[9]  = mk(O, O, 0,      O, O, I, I, 0,      'h14);
    tbl[10] = mk(O, I, 'h103,  I, O, I, I, 0,      'h14);
    tbl[11] = mk(O, O, 0,      I, I, I, O, 'h100,  'h100);
    tbl[12] = mk(O, O, 0,      O, O, I, I, 0,      'h104);
    #1 do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].p, tbl[i].r, tbl[i].rpc, tbl[i].a, {16'hC0DE, 16'(i)}, v, p_, rq, a_, fl);
      chk($sformatf("tbl%0d_valid", i), {31'b0, v}, {31'b0, tbl[i].ev});
      chk($sformatf("tbl%0d_req", i), {31'b0, rq}, {31'b0, tbl[i].ereq});
      chk($sformatf("tbl%0d_flush", i), {31'b0, fl}, {31'b0, tbl[i].efl});
      chk($sformatf("tbl%0d_pc", i), p_, tbl[i].epc);
      chk($sformatf("tbl%0d_addr", i), a_, tbl[i].eaddr);
    end
    // Redirect while the request at 0x8 is unacked; its late data must never surface.
    do_reset();
    cyc(0, 0, 0, 0, 0, v, p_, rq, a_, fl);
    cyc(0, 0, 0, 1, 32'h1111_0000, v, p_, rq, a_, fl);
    cyc(0, 0, 0, 1, 32'h1111_0004, v, p_, rq, a_, fl);
    cyc(0, 1, 32'h200, 0, 0, v, p_, rq, a_, fl);
    chk("drop_v0", {31'b0, v}, 0);
    cyc(0, 0, 0, 0, 0, v, p_, rq, a_, fl);
    chk("drop_v1", {31'b0, v}, 0);
    chk("drop_addr", a_, 32'h8);
    cyc(0, 0, 0, 1, 32'hDEAD_0008, v, p_, rq, a_, fl);
    chk("drop_v2", {31'b0, v}, 0);
    chk("drop_pc", p_, 0);
    cyc(0, 0, 0, 1, 32'h2222_0200, v, p_, rq, a_, fl);
    chk("drop_next", a_, 32'h200);
    // Address wrap past the top of memory.
    cyc(0, 1, 32'hFFFF_FFFE, 1, 0, v, p_, rq, a_, fl);
    cyc(0, 0, 0, 1, 32'h3333_FFFC, v, p_, rq, a_, fl);
    chk("wrap_pc", p_, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, v, p_, rq, a_, fl);
    chk("wrap_addr", a_, 32'h0);
    // Reset while in DROP; the stale ack then lands in BOOT.
    do_reset();
    cyc(0, 0, 0, 0, 0, v, p_, rq, a_, fl);
    cyc(0, 1, 32'h40, 0, 0, v, p_, rq, a_, fl);
    do_reset();
    cyc(0, 0, 0, 1, 32'hBAD0_0000, v, p_, rq, a_, fl);
    chk("late_ack_req", {31'b0, rq}, 0);
    chk("late_ack_valid", {31'b0, v}, 0);
    cyc(0, 0, 0, 1, 32'h4444_0000, v, p_, rq, a_, fl);
    chk("restart_addr", a_, RESET_PC);
    chk("restart_valid", {31'b0, v}, 1);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom,
          $urandom_range(0, 1) == 1, $urandom, v, p_, rq, a_, fl);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
